// File: rtl/lab2_proc_imem_resp_drop_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lab2_proc_imem_resp_drop_unit_pkg
//  Description : Shared constants and the 4-byte memory response message
//                type used by the imem response drop unit.
//  Revision    : 1.0  initial release
// ============================================================================
package lab2_proc_imem_resp_drop_unit_pkg;

    // Maximum number of instruction fetches allowed in flight.
    localparam int IMEM_MAX_INFLIGHT = 4;

    // 4-byte memory response message.
    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage
`default_nettype wire

// File: rtl/lab2_proc_imem_resp_queue.sv
`default_nettype none
// ============================================================================
//  Module      : lab2_proc_imem_resp_queue
//  Description : Small circular-buffer queue holding correct-path imem
//                responses until the D stage accepts them. A synchronous
//                clear empties it, overriding any enq/deq in that cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module lab2_proc_imem_resp_queue
    import lab2_proc_imem_resp_drop_unit_pkg::*;
#(
    parameter int NUM_ENTRIES = 2
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enq_val,
    output logic         enq_rdy,
    input  mem_resp_4B_t enq_msg,
    output logic         deq_val,
    input  logic         deq_rdy,
    output mem_resp_4B_t deq_msg
);

    localparam int c_PTR_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int c_CNT_W = $clog2(NUM_ENTRIES + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(NUM_ENTRIES - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(NUM_ENTRIES);
    localparam logic [c_CNT_W-1:0] c_ONE_CNT  = c_CNT_W'(1);

    mem_resp_4B_t         r_mem [NUM_ENTRIES];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_enq;
    logic                 w_deq;

    // Readiness is based on the registered count only, so a full queue
    // never accepts even when a dequeue happens in the same cycle.
    assign enq_rdy = (r_count != c_FULL_CNT);
    assign deq_val = (r_count != '0);
    assign deq_msg = r_mem[r_head];

    assign w_enq = enq_val && enq_rdy;
    assign w_deq = deq_val && deq_rdy;

    // Data storage: written at the tail on every accepted enqueue.
    always_ff @(posedge clk) begin
        if (w_enq && !clear) begin
            r_mem[r_tail] <= enq_msg;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo NUM_ENTRIES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= (r_tail == c_LAST_PTR) ? '0 : r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= (r_head == c_LAST_PTR) ? '0 : r_head + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + c_ONE_CNT;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - c_ONE_CNT;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lab2_proc_imem_resp_drop_unit.sv
`default_nettype none
// ============================================================================
//  Module      : lab2_proc_imem_resp_drop_unit
//  Description : Tracks in-flight imem requests, silently consumes wrong-path
//                responses after a squash, and buffers correct-path
//                responses for the D stage.
//  Revision    : 1.0  initial release
// ============================================================================
module lab2_proc_imem_resp_drop_unit
    import lab2_proc_imem_resp_drop_unit_pkg::*;
#(
    parameter int MAX_INFLIGHT = IMEM_MAX_INFLIGHT,
    parameter int NUM_ENTRIES  = 2
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         req_fire,
    output logic         req_rdy,
    input  logic         squash,
    input  logic         in_val,
    output logic         in_rdy,
    input  mem_resp_4B_t in_msg,
    output logic         out_val,
    input  logic         out_rdy,
    output mem_resp_4B_t out_msg,
    output logic         dropping
);

    localparam int c_CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_INFLIGHT);
    localparam logic [c_CNT_W-1:0] c_ONE_CNT = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_drop_cnt;
    logic [c_CNT_W-1:0] w_outstanding_next;
    logic [c_CNT_W-1:0] w_drop_cnt_next;

    logic               w_drop_mode;
    logic               w_in_fire;
    logic               w_q_enq_val;
    logic               w_q_enq_rdy;
    logic               w_q_deq_val;
    logic               w_q_deq_rdy;

    assign w_drop_mode = (r_drop_cnt != '0);
    assign dropping    = w_drop_mode;
    assign req_rdy     = (r_outstanding < c_MAX_CNT);

    // During a squash or while draining dead responses, memory is never
    // back-pressured; otherwise acceptance depends on queue space.
    assign in_rdy    = (squash || w_drop_mode) ? 1'b1 : w_q_enq_rdy;
    assign w_in_fire = in_val && in_rdy;

    // Only correct-path responses reach the queue.
    assign w_q_enq_val = in_val && !squash && !w_drop_mode;

    // A squash hides the queue head from D in the same cycle it is cleared.
    assign out_val     = w_q_deq_val && !squash;
    assign w_q_deq_rdy = out_rdy && !squash;

    lab2_proc_imem_resp_queue #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .clear   (squash),
        .enq_val (w_q_enq_val),
        .enq_rdy (w_q_enq_rdy),
        .enq_msg (in_msg),
        .deq_val (w_q_deq_val),
        .deq_rdy (w_q_deq_rdy),
        .deq_msg (out_msg)
    );

    // Next-state for the in-flight and drop counters.
    always_comb begin
        w_outstanding_next = r_outstanding;
        w_drop_cnt_next    = r_drop_cnt;

        if (req_fire && !w_in_fire) begin
            w_outstanding_next = r_outstanding + c_ONE_CNT;
        end else if (!req_fire && w_in_fire) begin
            w_outstanding_next = r_outstanding - c_ONE_CNT;
        end

        // The redirect target fetched in the squash cycle is not counted
        // as dead; the response arriving in the squash cycle is already gone.
        if (squash) begin
            w_drop_cnt_next = r_outstanding - (w_in_fire ? c_ONE_CNT : '0);
        end else if (w_drop_mode && w_in_fire) begin
            w_drop_cnt_next = r_drop_cnt - c_ONE_CNT;
        end
    end

    // Counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            r_drop_cnt    <= w_drop_cnt_next;
        end
    end

    // A response with nothing in flight means memory and unit disagree.
    always @(posedge clk) begin
        if (reset && w_in_fire) begin
            assert (r_outstanding != '0);
        end
    end

endmodule
`default_nettype wire
